// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// one-cycle execute, and a registered response held until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [3:0]  ALU_OP_NOP = 4'h0
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,

  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;

  logic             prio_q, prio_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant_valid;
  logic             grant_id;
  logic             accept_req;
  logic             accept_rsp;

  // prio names the requester that wins when both are valid at once.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = prio_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Ready only asserts toward a valid requester, so ready alone marks the handshake.
  assign accept_req = rst_n && (state_q == IDLE) && grant_valid;
  assign accept_rsp = (state_q == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept_req && !grant_id;
    req1_ready = accept_req &&  grant_id;
    alu_op     = (state_q == EXEC) ? op_q : ALU_OP_NOP;
    alu_a      = a_q;
    alu_b      = b_q;
    rsp_valid  = rsp_valid_q;
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_zero   = rsp_zero_q;
  end

  // Operand capture on grant; the ALU output is sampled exactly once, at the end of EXEC.
  always_comb begin
    prio_d       = prio_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    if (accept_req) begin
      op_d   = grant_id ? req1_op : req0_op;
      a_d    = grant_id ? req1_a  : req0_a;
      b_d    = grant_id ? req1_b  : req0_b;
      id_d   = grant_id;
      prio_d = ~grant_id;
    end

    if (state_q == EXEC) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = id_q;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
    end

    if (accept_rsp) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      op_q         <= ALU_OP_NOP;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared port and a
// short randomised phase checked against an in-order expectation queue.
module tb_alu_arbiter;

  localparam int W = 32;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [W-1:0] rsp_result;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    n_total = n_total + 1;
    assert (observed === expected) n_pass = n_pass + 1;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    n_total = n_total + 1;
    assert (observed === expected) n_pass = n_pass + 1;
    else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input logic v1, input logic [3:0] op1,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkFlag({tag, "_req0_ready"}, req0_ready, 1'b0);
    checkFlag({tag, "_req1_ready"}, req1_ready, 1'b0);
    checkFlag({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    checkFlag({tag, "_rsp_id"}, rsp_id, 1'b0);
    checkFlag({tag, "_rsp_zero"}, rsp_zero, 1'b0);
    checkOutput({tag, "_rsp_result"}, rsp_result, '0);
    checkOutput({tag, "_alu_op"}, {{(W-4){1'b0}}, alu_op}, {{(W-4){1'b0}}, OP_NOP});
    checkOutput({tag, "_alu_a"}, alu_a, '0);
    checkOutput({tag, "_alu_b"}, alu_b, '0);
  endtask

  // Holds reset with both requesters valid, then releases on a falling edge.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b1);
    @(negedge clk);
    checkResetValues(tag);
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  // Waits for one grant and its response, checking owner, result, flag and latency.
  task automatic serveExpect(input string tag, input logic exp_id, input logic [W-1:0] exp_res,
                             input logic exp_zero);
    bit got;
    int lat;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        checkFlag({tag, "_grant_id"}, req1_ready, exp_id);
      end
      tick();
    end
    checkFlag({tag, "_granted"}, got, 1'b1);
    got = 1'b0;
    lat = 1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        checkOutput({tag, "_latency"}, lat, 32'd2);
        checkFlag({tag, "_rsp_id"}, rsp_id, exp_id);
        checkOutput({tag, "_rsp_result"}, rsp_result, exp_res);
        checkFlag({tag, "_rsp_zero"}, rsp_zero, exp_zero);
        rsp_ready = 1'b1;
        #1;
        checkFlag({tag, "_no_grant_on_accept"}, req0_ready | req1_ready, 1'b0);
        tick();
        rsp_ready = 1'b0;
      end else begin
        lat++;
        tick();
      end
    end
    checkFlag({tag, "_rsp_seen"}, got, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic granted0, granted1;
    exp_t e;

    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b0);
    doReset("rst0");

    // Single requester: ADD 5+7.
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, OP_NOP, '0, '0, 1'b0);
    @(negedge clk);
    checkFlag("t1_req0_ready", req0_ready, 1'b1);
    checkFlag("t1_req1_ready", req1_ready, 1'b0);
    checkOutput("t1_idle_alu_op", {{(W-4){1'b0}}, alu_op}, {{(W-4){1'b0}}, OP_NOP});
    tick();
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b1, OP_SUB, 32'd9, 32'd1, 1'b0);
    @(negedge clk);
    checkOutput("t1_exec_alu_op", {{(W-4){1'b0}}, alu_op}, {{(W-4){1'b0}}, OP_ADD});
    checkOutput("t1_exec_alu_a", alu_a, 32'd5);
    checkOutput("t1_exec_alu_b", alu_b, 32'd7);
    checkFlag("t1_exec_req1_ready", req1_ready, 1'b0);
    checkFlag("t1_exec_rsp_valid", rsp_valid, 1'b0);
    tick();
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b0);
    @(negedge clk);
    checkFlag("t1_rsp_valid", rsp_valid, 1'b1);
    checkFlag("t1_rsp_id", rsp_id, 1'b0);
    checkOutput("t1_rsp_result", rsp_result, 32'd12);
    checkFlag("t1_rsp_zero", rsp_zero, 1'b0);
    checkOutput("t1_resp_alu_op", {{(W-4){1'b0}}, alu_op}, {{(W-4){1'b0}}, OP_NOP});
    checkOutput("t1_resp_alu_a_held", alu_a, 32'd5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    checkFlag("t1_rsp_valid_cleared", rsp_valid, 1'b0);
    tick();

    // Contention straight after reset: req0 wins, then req1.
    doReset("rst1");
    applyStimulus(1'b1, OP_SUB, 32'd3, 32'd3, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
    serveExpect("t2_first", 1'b0, 32'd0, 1'b1);
    serveExpect("t2_second", 1'b1, 32'd2, 1'b0);
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b0);
    tick();

    // Both held valid for six grants: strict alternation.
    applyStimulus(1'b1, OP_AND, 32'hF0F0, 32'hFF00, 1'b1, OP_XOR, 32'hAAAA, 32'h5555, 1'b0);
    for (int g = 0; g < 6; g++) begin
      serveExpect($sformatf("t3_alt%0d", g), g[0], g[0] ? 32'hFFFF : 32'hF000, 1'b0);
    end
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b0);
    tick();

    // Response stalled five cycles while req0 waits.
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b1, OP_OR, 32'h12, 32'h21, 1'b0);
    @(negedge clk);
    checkFlag("t4_req1_ready", req1_ready, 1'b1);
    tick();
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, OP_NOP, '0, '0, 1'b0);
    tick();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkFlag($sformatf("t4_stall%0d_rsp_valid", s), rsp_valid, 1'b1);
      checkFlag($sformatf("t4_stall%0d_rsp_id", s), rsp_id, 1'b1);
      checkOutput($sformatf("t4_stall%0d_rsp_result", s), rsp_result, 32'h33);
      checkFlag($sformatf("t4_stall%0d_ready", s), req0_ready | req1_ready, 1'b0);
      checkOutput($sformatf("t4_stall%0d_alu_op", s), {{(W-4){1'b0}}, alu_op},
                  {{(W-4){1'b0}}, OP_NOP});
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkFlag("t4_accept_no_grant", req0_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    checkFlag("t4_req0_ready_after", req0_ready, 1'b1);
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    checkFlag("t4_drop_no_exec", rsp_valid, 1'b0);
    checkOutput("t4_drop_alu_op", {{(W-4){1'b0}}, alu_op}, {{(W-4){1'b0}}, OP_NOP});
    tick();

    // Reset pulsed while an ADD is executing.
    applyStimulus(1'b1, OP_ADD, 32'd9, 32'd9, 1'b0, OP_NOP, '0, '0, 1'b0);
    @(negedge clk);
    checkFlag("t5_req0_ready", req0_ready, 1'b1);
    tick();
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b1);
    checkOutput("t5_exec_alu_op", {{(W-4){1'b0}}, alu_op}, {{(W-4){1'b0}}, OP_ADD});
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("t5_mid");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checkFlag($sformatf("t5_post%0d_rsp_valid", s), rsp_valid, 1'b0);
      tick();
    end
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b1, OP_ADD, 32'd2, 32'd3, 1'b0);
    serveExpect("t5_regrant", 1'b1, 32'd5, 1'b0);
    applyStimulus(1'b0, OP_NOP, '0, '0, 1'b0, OP_NOP, '0, '0, 1'b0);
    tick();

    // Randomised traffic against the expectation queue, then drain.
    granted0 = 1'b0;
    granted1 = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        if (granted0) begin
          req0_valid = 1'b0;
          granted0   = 1'b0;
        end else if (!req0_valid && ($urandom % 2 == 0)) begin
          req0_valid = 1'b1;
          req0_op    = 4'($urandom_range(1, 7));
          req0_a     = $urandom;
          req0_b     = ($urandom % 4 == 0) ? req0_a : $urandom;
        end
        if (granted1) begin
          req1_valid = 1'b0;
          granted1   = 1'b0;
        end else if (!req1_valid && ($urandom % 2 == 0)) begin
          req1_valid = 1'b1;
          req1_op    = 4'($urandom_range(1, 7));
          req1_a     = $urandom;
          req1_b     = ($urandom % 4 == 0) ? req1_a : $urandom;
        end
        rsp_ready = 1'($urandom % 2);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
      end
      @(negedge clk);
      if (req0_ready && req1_ready) checkFlag("rnd_dual_ready", 1'b1, 1'b0);
      if (req0_valid && req0_ready) begin
        e.id   = 1'b0;
        e.res  = alu_model(req0_op, req0_a, req0_b);
        e.zero = (e.res == '0);
        exp_q.push_back(e);
        granted0 = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        e.id   = 1'b1;
        e.res  = alu_model(req1_op, req1_a, req1_b);
        e.zero = (e.res == '0);
        exp_q.push_back(e);
        granted1 = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checkFlag("rnd_unexpected_rsp", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          checkFlag($sformatf("rnd%0d_rsp_id", cyc), rsp_id, e.id);
          checkOutput($sformatf("rnd%0d_rsp_result", cyc), rsp_result, e.res);
          checkFlag($sformatf("rnd%0d_rsp_zero", cyc), rsp_zero, e.zero);
        end
      end
      tick();
    end
    checkOutput("rnd_queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
